// File: rtl/c2f_chunk_sched.sv
// Read-side scheduler for the CPU->FPGA chunk ring: fetches published chunks from the
// byte-enable RAM and streams them as valid/ready 64-bit words, retiring each chunk with dtAck.
//
// state | meaning
// IDLE  | no chunk being fetched; waits for enable and fetchIdx != wrPtr
// FETCH | issuing qword reads of chunk fetchIdx while the output buffer has room
module c2f_chunk_sched #(
    parameter int INDEX_NBITS  = 3,
    parameter int OFFSET_NBITS = 4
) (
    input  logic                    sysClk,
    input  logic                    sysRst_n,
    input  logic                    enable,
    input  logic [INDEX_NBITS-1:0]  wrPtr,
    output logic [INDEX_NBITS-1:0]  ramIndex,
    output logic [OFFSET_NBITS-1:0] ramOffset,
    input  logic [63:0]             ramData,
    output logic [63:0]             dataOut,
    output logic                    dataValid,
    output logic                    dataLast,
    input  logic                    dataReady,
    output logic                    dtAck,
    output logic [INDEX_NBITS-1:0]  rdIndex,
    output logic                    empty
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_NBITS-1:0]  fetch_idx_q, fetch_idx_d, fetch_idx_inc;
    logic [OFFSET_NBITS-1:0] offset_q, offset_d;
    logic                    issue;

    logic                    inflight_q;
    logic                    inflight_last_q;

    logic [64:0]             buf_q [0:1];
    logic                    buf_head_q;
    logic [1:0]              buf_cnt_q;
    logic                    buf_nonempty;
    logic [1:0]              occupancy;
    logic [64:0]             buf_head_word;
    logic                    wr_slot;
    logic                    push;
    logic                    pop;
    logic                    accept;

    logic                    dt_ack_q;
    logic [INDEX_NBITS-1:0]  rd_index_q;

    assign fetch_idx_inc = fetch_idx_q + INDEX_NBITS'(1);
    assign buf_nonempty  = (buf_cnt_q != 2'd0);
    assign occupancy     = buf_cnt_q + {1'b0, inflight_q};
    assign buf_head_word = buf_q[buf_head_q];
    assign wr_slot       = buf_head_q ^ buf_cnt_q[0];

    always_comb begin
        state_d     = state_q;
        fetch_idx_d = fetch_idx_q;
        offset_d    = offset_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (fetch_idx_q != wrPtr)) begin
                    state_d  = ST_FETCH;
                    offset_d = '0;
                end
            end
            ST_FETCH: begin
                if (occupancy < 2'd2) begin
                    issue    = 1'b1;
                    offset_d = offset_q + OFFSET_NBITS'(1);
                    if (&offset_q) begin
                        // wrPtr is only looked at here, at the chunk boundary
                        fetch_idx_d = fetch_idx_inc;
                        if (!(enable && (fetch_idx_inc != wrPtr))) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q         <= ST_IDLE;
            fetch_idx_q     <= '0;
            offset_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_idx_q     <= fetch_idx_d;
            offset_q        <= offset_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (&offset_q);
        end
    end

    // The word returning from RAM bypasses the buffer when the buffer is empty and the
    // consumer takes it straight away; otherwise it is parked in the free slot.
    assign accept = dataValid && dataReady;
    assign push   = inflight_q && !(!buf_nonempty && dataReady);
    assign pop    = accept && buf_nonempty;

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            buf_head_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_slot] <= {inflight_last_q, ramData};
            end
            if (pop) begin
                buf_head_q <= ~buf_head_q;
            end
            case ({push, pop})
                2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
                2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    always_comb begin
        dataValid = buf_nonempty || inflight_q;
        dataOut   = '0;
        dataLast  = 1'b0;
        if (buf_nonempty) begin
            dataLast = buf_head_word[64];
            dataOut  = buf_head_word[63:0];
        end else if (inflight_q) begin
            dataLast = inflight_last_q;
            dataOut  = ramData;
        end
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            dt_ack_q   <= 1'b0;
            rd_index_q <= '0;
        end else begin
            dt_ack_q <= accept && dataLast;
            if (accept && dataLast) begin
                rd_index_q <= rd_index_q + INDEX_NBITS'(1);
            end
        end
    end

    assign ramIndex  = fetch_idx_q;
    assign ramOffset = offset_q;
    assign dtAck     = dt_ack_q;
    assign rdIndex   = rd_index_q;
    assign empty     = (state_q == ST_IDLE) && !buf_nonempty && !inflight_q
                       && (fetch_idx_q == wrPtr);

endmodule
